// File: rtl/reloj_pkg.sv
// Shared clock/calendar definitions: FSM encoding, BCD limits and range helper.
package reloj_pkg;

    localparam int unsigned BCD_DIGIT_MAX = 9;
    localparam int unsigned RDD_ITER      = 8;
    localparam int unsigned ITER_W        = 3;
    localparam int unsigned BIN_W         = 8;
    localparam int unsigned MM_MAX        = 59;
    localparam int unsigned HH_MAX        = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] digit1;
        logic [3:0] digit0;
    } bcd2_t;

    // Both digits decimal and the two-digit value no larger than max_val.
    function automatic logic bcd2_in_range(input bcd2_t b, input logic [7:0] max_val);
        logic [7:0] v;
        v = (8'(b.digit1) * 8'd10) + 8'(b.digit0);
        return (b.digit1 <= 4'(BCD_DIGIT_MAX)) &&
               (b.digit0 <= 4'(BCD_DIGIT_MAX)) &&
               (v <= max_val);
    endfunction

endpackage

// File: rtl/bcd_rdd_step.sv
// One reverse double-dabble iteration: shift {bcd,bin} right, then pull each
// BCD nibble that reached 8 or more back down by 3.
module bcd_rdd_step #(
    parameter int unsigned NDIG = 2,
    parameter int unsigned BW   = 8
) (
    input  logic [4*NDIG-1:0] bcd_i,
    input  logic [BW-1:0]     bin_i,
    output logic [4*NDIG-1:0] bcd_o,
    output logic [BW-1:0]     bin_o
);

    logic [4*NDIG-1:0] bcd_sh;

    always_comb begin
        {bcd_sh, bin_o} = {1'b0, bcd_i, bin_i[BW-1:1]};
        bcd_o = bcd_sh;
        for (int d = 0; d < int'(NDIG); d++) begin
            if (bcd_sh[4*d +: 4] >= 4'd8) begin
                bcd_o[4*d +: 4] = bcd_sh[4*d +: 4] - 4'd3;
            end
        end
    end

endmodule

// File: rtl/lector_bcd_mm.sv
// Serial 2-digit BCD to binary reader with range check and valid/ready on
// both sides; result is ready to load into a minutes/hours counter.
module lector_bcd_mm
    import reloj_pkg::*;
#(
    parameter int unsigned N       = 6,
    parameter int unsigned MAX_VAL = 59
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   datos_in,
    input  logic         datos_in_valid,
    output logic         datos_in_ready,
    output logic [N-1:0] q_out,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         error
);

    localparam logic [7:0] MAX_B = 8'(MAX_VAL);

    state_e            state_q, state_d;
    logic [7:0]        bcd_q, bcd_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [N-1:0]      q_out_q, q_out_d;
    logic              q_valid_q, q_valid_d;
    logic              error_q, error_d;

    logic [7:0]        step_bcd;
    logic [BIN_W-1:0]  step_bin;

    bcd_rdd_step #(
        .NDIG (2),
        .BW   (BIN_W)
    ) u_step (
        .bcd_i (bcd_q),
        .bin_i (bin_q),
        .bcd_o (step_bcd),
        .bin_o (step_bin)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            iter_q    <= '0;
            q_out_q   <= '0;
            q_valid_q <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            iter_q    <= iter_d;
            q_out_q   <= q_out_d;
            q_valid_q <= q_valid_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        iter_d    = iter_q;
        q_out_d   = q_out_q;
        q_valid_d = q_valid_q;
        error_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (datos_in_valid) begin
                    if (bcd2_in_range(bcd2_t'(datos_in), MAX_B)) begin
                        state_d = ST_CONV;
                        bcd_d   = datos_in;
                        bin_d   = '0;
                        iter_d  = '0;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            ST_CONV: begin
                bcd_d  = step_bcd;
                bin_d  = step_bin;
                iter_d = iter_q + ITER_W'(1);
                // Final iteration: the step output already holds the full result.
                if (iter_q == ITER_W'(RDD_ITER - 1)) begin
                    state_d   = ST_DONE;
                    q_out_d   = N'(step_bin);
                    q_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (q_ready) begin
                    state_d   = ST_IDLE;
                    q_valid_d = 1'b0;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign datos_in_ready = (state_q == ST_IDLE);
    assign q_out          = q_out_q;
    assign q_valid        = q_valid_q;
    assign error          = error_q;

endmodule

// File: tb/tb_lector_bcd_mm.sv
// Randomized self-checking bench for lector_bcd_mm (MAX_VAL=59 and MAX_VAL=23 instances).
module tb_lector_bcd_mm;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] datos_in;
    logic       valid_a, valid_b, q_ready;
    logic       ready_a, ready_b, qv_a, qv_b, err_a, err_b;
    logic [5:0] q_a;
    logic [4:0] q_b;

    int tests = 0;
    int fails = 0;
    int last_q [2];

    always #5 clk = ~clk;

    lector_bcd_mm #(.N(6), .MAX_VAL(59)) dut_a (
        .clk            (clk),
        .reset          (reset),
        .datos_in       (datos_in),
        .datos_in_valid (valid_a),
        .datos_in_ready (ready_a),
        .q_out          (q_a),
        .q_valid        (qv_a),
        .q_ready        (q_ready),
        .error          (err_a)
    );

    lector_bcd_mm #(.N(5), .MAX_VAL(23)) dut_b (
        .clk            (clk),
        .reset          (reset),
        .datos_in       (datos_in),
        .datos_in_valid (valid_b),
        .datos_in_ready (ready_b),
        .q_out          (q_b),
        .q_valid        (qv_b),
        .q_ready        (q_ready),
        .error          (err_b)
    );

    // Decimal meaning of a BCD byte, or -1 when it must be rejected.
    function automatic int model(input logic [7:0] b, input int maxv);
        int d1, d0;
        d1 = int'(b[7:4]);
        d0 = int'(b[3:0]);
        if (d1 > 9 || d0 > 9 || (d1 * 10 + d0) > maxv) return -1;
        return d1 * 10 + d0;
    endfunction

    function automatic int cur_q(input bit sel);
        return sel ? int'(q_b) : int'(q_a);
    endfunction

    // Present one byte to the selected instance and observe until result or error.
    task automatic send(input bit sel, input logic [7:0] b, input logic qr,
                        output int lat, output int q, output bit err_seen,
                        output bit ready_leak);
        @(negedge clk);
        datos_in = b;
        q_ready  = qr;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        lat = 0; q = -1; err_seen = 1'b0; ready_leak = 1'b0;
        while (lat < 20) begin
            if (sel ? err_b : err_a) begin
                err_seen = 1'b1;
                break;
            end
            if (sel ? qv_b : qv_a) begin
                q = cur_q(sel);
                break;
            end
            if (sel ? ready_b : ready_a) ready_leak = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        tests++;
        if (ready_a !== 1'b1 || qv_a !== 1'b0 || err_a !== 1'b0 || q_a !== 6'd0) begin
            fails++;
            $display("FAIL reset_a: ready=%b qv=%b err=%b q=%0d, expected 1 0 0 0", ready_a, qv_a, err_a, q_a);
        end
        tests++;
        if (ready_b !== 1'b1 || qv_b !== 1'b0 || err_b !== 1'b0 || q_b !== 5'd0) begin
            fails++;
            $display("FAIL reset_b: ready=%b qv=%b err=%b q=%0d, expected 1 0 0 0", ready_b, qv_b, err_b, q_b);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        last_q[0] = 0;
        last_q[1] = 0;
    endtask

    task automatic test_first();
        int lat, q; bit e, leak;
        send(1'b0, 8'h59, 1'b1, lat, q, e, leak);
        tests++;
        if (lat != 8 || q != 59 || e || leak || ready_a !== 1'b0) begin
            fails++;
            $display("FAIL first_59: lat=%0d q=%0d err=%0b leak=%0b ready=%b, expected 8 59 0 0 0", lat, q, e, leak, ready_a);
        end
        @(negedge clk);
        tests++;
        if (qv_a !== 1'b0 || ready_a !== 1'b1) begin
            fails++;
            $display("FAIL first_release: qv=%b ready=%b, expected 0 1", qv_a, ready_a);
        end
        last_q[0] = 59;
    endtask

    task automatic test_sweep();
        logic [7:0] vec [4] = '{8'h00, 8'h09, 8'h10, 8'h37};
        int lat, q, exp; bit e, leak;
        foreach (vec[i]) begin
            exp = model(vec[i], 59);
            send(1'b0, vec[i], 1'b1, lat, q, e, leak);
            tests++;
            if (lat != 8 || q != exp || e || leak) begin
                fails++;
                $display("FAIL sweep_%02h: lat=%0d q=%0d err=%0b leak=%0b, expected 8 %0d 0 0", vec[i], lat, q, e, leak, exp);
            end
            @(negedge clk);
            last_q[0] = exp;
        end
    endtask

    task automatic test_errors();
        logic [7:0] vec [2] = '{8'h60, 8'h3A};
        int lat, q; bit e, leak;
        foreach (vec[i]) begin
            send(1'b0, vec[i], 1'b1, lat, q, e, leak);
            tests++;
            if (!e || lat != 0 || qv_a !== 1'b0 || int'(q_a) != last_q[0]) begin
                fails++;
                $display("FAIL error_%02h: err=%0b lat=%0d qv=%b q=%0d, expected 1 0 0 %0d", vec[i], e, lat, qv_a, q_a, last_q[0]);
            end
            @(negedge clk);
            tests++;
            if (err_a !== 1'b0 || ready_a !== 1'b1 || qv_a !== 1'b0) begin
                fails++;
                $display("FAIL error_pulse_%02h: err=%b ready=%b qv=%b, expected 0 1 0", vec[i], err_a, ready_a, qv_a);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, q; bit e, leak, held;
        send(1'b0, 8'h42, 1'b0, lat, q, e, leak);
        tests++;
        if (lat != 8 || q != 42 || e) begin
            fails++;
            $display("FAIL bp_result: lat=%0d q=%0d err=%0b, expected 8 42 0", lat, q, e);
        end
        held = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (qv_a !== 1'b1 || q_a !== 6'd42 || ready_a !== 1'b0 || err_a !== 1'b0) held = 1'b0;
            if (i == 1) begin
                datos_in = 8'h11;
                valid_a  = 1'b1;
            end
        end
        tests++;
        if (!held) begin
            fails++;
            $display("FAIL bp_hold: qv=%b q=%0d ready=%b err=%b, expected 1 42 0 0", qv_a, q_a, ready_a, err_a);
        end
        q_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (qv_a !== 1'b0 || ready_a !== 1'b1 || q_a !== 6'd42) begin
            fails++;
            $display("FAIL bp_handshake: qv=%b ready=%b q=%0d, expected 0 1 42", qv_a, ready_a, q_a);
        end
        valid_a = 1'b0;
        q_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (ready_a !== 1'b1 || qv_a !== 1'b0 || err_a !== 1'b0) begin
            fails++;
            $display("FAIL bp_ignored: ready=%b qv=%b err=%b, expected 1 0 0", ready_a, qv_a, err_a);
        end
        last_q[0] = 42;
    endtask

    task automatic test_reset_mid();
        int lat, q; bit e, leak, quiet;
        @(negedge clk);
        datos_in = 8'h25;
        q_ready  = 1'b1;
        valid_a  = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (ready_a !== 1'b1 || qv_a !== 1'b0 || err_a !== 1'b0 || q_a !== 6'd0) begin
            fails++;
            $display("FAIL midreset_now: ready=%b qv=%b err=%b q=%0d, expected 1 0 0 0", ready_a, qv_a, err_a, q_a);
        end
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (qv_a !== 1'b0 || err_a !== 1'b0) quiet = 1'b0;
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (qv_a !== 1'b0 || err_a !== 1'b0) quiet = 1'b0;
        end
        tests++;
        if (!quiet) begin
            fails++;
            $display("FAIL midreset_quiet: qv=%b err=%b, expected 0 0", qv_a, err_a);
        end
        send(1'b0, 8'h42, 1'b1, lat, q, e, leak);
        tests++;
        if (lat != 8 || q != 42 || e) begin
            fails++;
            $display("FAIL midreset_after: lat=%0d q=%0d err=%0b, expected 8 42 0", lat, q, e);
        end
        @(negedge clk);
        last_q[0] = 42;
        last_q[1] = 0;
    endtask

    task automatic test_max23();
        int lat, q; bit e, leak;
        send(1'b1, 8'h23, 1'b1, lat, q, e, leak);
        tests++;
        if (lat != 8 || q != 23 || e) begin
            fails++;
            $display("FAIL max23_ok: lat=%0d q=%0d err=%0b, expected 8 23 0", lat, q, e);
        end
        @(negedge clk);
        send(1'b1, 8'h24, 1'b1, lat, q, e, leak);
        tests++;
        if (!e || lat != 0 || qv_b !== 1'b0 || q_b !== 5'd23) begin
            fails++;
            $display("FAIL max23_err: err=%0b lat=%0d qv=%b q=%0d, expected 1 0 0 23", e, lat, qv_b, q_b);
        end
        @(negedge clk);
        tests++;
        if (err_b !== 1'b0 || ready_b !== 1'b1) begin
            fails++;
            $display("FAIL max23_pulse: err=%b ready=%b, expected 0 1", err_b, ready_b);
        end
        last_q[1] = 23;
    endtask

    task automatic test_random();
        int lat, q, exp; bit e, leak, sel;
        logic [7:0] b;
        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0)
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                b = 8'($urandom);
            exp = model(b, sel ? 23 : 59);
            send(sel, b, 1'b1, lat, q, e, leak);
            tests++;
            if (exp < 0) begin
                if (!e || lat != 0 || cur_q(sel) != last_q[sel]) begin
                    fails++;
                    $display("FAIL rand_err dut%0d %02h: err=%0b lat=%0d q=%0d, expected 1 0 %0d", sel, b, e, lat, cur_q(sel), last_q[sel]);
                end
            end else begin
                if (e || lat != 8 || q != exp || leak) begin
                    fails++;
                    $display("FAIL rand_conv dut%0d %02h: err=%0b lat=%0d q=%0d leak=%0b, expected 0 8 %0d 0", sel, b, e, lat, q, leak, exp);
                end
                last_q[sel] = exp;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        datos_in = 8'h00;
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        q_ready  = 1'b0;
        test_reset();
        test_first();
        test_sweep();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_max23();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lector_bcd_mm.md
Name: lector_bcd_mm

Overview:
Sequential 2-digit BCD-to-binary decoder, the inverse of the minutes/hours counters that emit {digit1,digit0} BCD bytes. It accepts a BCD byte read back from the RTC data bus (or any BCD source), validates it against a range limit, and converts it by serial reverse double-dabble. The result is a binary count suitable for loading into a counter's q_act. Valid/ready handshakes are used on both sides.

Parameters:
N, 6, width of the binary output (6 bits covers 0..59).
MAX_VAL, 59, largest legal decoded value; 59 for minutes/seconds, 23 for hours.

Ports:
clk  input  1  system clock, 100 MHz.
reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately.
datos_in  input  8  BCD byte {digit1[7:4], digit0[3:0]}.
datos_in_valid  input  1  datos_in is valid this cycle.
datos_in_ready  output  1  block can accept; high only in IDLE.
q_out  output  N  decoded binary value.
q_valid  output  1  q_out holds a fresh result.
q_ready  input  1  consumer takes the result.
error  output  1  one-cycle pulse: rejected input.

Behaviour:
- Reset (reset=0) values:
  - state=IDLE, q_out=0, q_valid=0, error=0.
  - datos_in_ready=1.
  - Internal shift register and iteration counter cleared.
- FSM states: IDLE, CONV, DONE, ERR. datos_in_ready is 1 in IDLE only; it is decoded from state, not registered separately.
- IDLE, accept on datos_in_valid && datos_in_ready at edge t0:
  - If digit1>9, digit0>9, or (digit1*10+digit0)>MAX_VAL, go to ERR.
  - Otherwise load bcd_reg=datos_in, bin_reg(8b)=0, iter=0, and go to CONV.
- CONV, one iteration per clock:
  - Shift {bcd_reg,bin_reg} right by 1.
  - For each BCD nibble of the shifted bcd_reg, if nibble>=8, subtract 3.
  - iter counts 0..7. On the 8th iteration (edge t0+8) load q_out=bin_reg[N-1:0] of the final value and go to DONE.
- DONE:
  - q_valid=1 and q_out stable.
  - On q_ready=1, go to IDLE and drop q_valid at the next edge.
  - q_out keeps its last value after the handshake.
- ERR:
  - error=1 for exactly one cycle, then go to IDLE.
  - q_out and q_valid are unchanged (q_valid is 0, since ERR is entered only from IDLE).
- Latency: input accepted at edge t0 gives q_valid=1 after edge t0+8. Throughput is one conversion per at least 10 cycles.
- Back-pressure: while in CONV, DONE or ERR, datos_in_ready=0. datos_in_valid is ignored and no input is buffered.
- Simultaneous events:
  - q_ready and datos_in_valid in the same DONE cycle: only the handshake completes; the new input is accepted at the earliest in the following IDLE cycle.
  - q_ready while not in DONE has no effect.
- Width rules:
  - Internal bin_reg is 8 bits, since the maximum checked value is 99 before the range test.
  - q_out is the truncation to N bits; this is safe because the value is ≤MAX_VAL.
  - Requirement: MAX_VAL < 2^N.
- Reset mid-operation: an asynchronous return to reset values from any state. A conversion in progress is aborted and produces no q_valid and no error.

Decomposition:
- Shared package (reloj_pkg):
  - FSM state encoding (2 bits).
  - BCD_DIGIT_MAX=9.
  - RDD_ITER=8.
  - MM_MAX=59, HH_MAX=23.
- Sub-module bcd_rdd_step: combinational single reverse double-dabble iteration (shift right + per-nibble subtract-3). It is instantiated once, fed back through the registers, and is reusable by a future 3-digit variant.

Test Plan:
1. datos_in=8'h59 with valid at t0, q_ready=1 → q_valid rises after edge t0+8 with q_out=59; datos_in_ready=0 during t0+1..t0+9.
2. Sweep 8'h00, 8'h09, 8'h10, 8'h37 → q_out=0, 9, 10, 37 respectively; error never asserted.
3. 8'h60 and 8'h3A (invalid digit) → error high exactly one cycle after accept, q_valid stays 0, q_out retains the previous value (37).
4. 8'h42 with q_ready=0 for 6 cycles after q_valid, and a second datos_in_valid (8'h11) during that time → q_out=42 held, ready=0, 8'h11 ignored; q_ready=1 then returns to IDLE with ready=1.
5. Drive reset=0 at iteration 4 of a conversion of 8'h25 → outputs go to reset values immediately, no q_valid or error. Release reset, then send 8'h42 → q_out=42 after 8 cycles.
6. Instance with MAX_VAL=23: 8'h23 → q_out=23; 8'h24 → one-cycle error pulse.
